// File: rtl/flux_sched_pkg.sv
// Shared types and the rotate-priority pick used by multi-flux actor schedulers.
package flux_sched_pkg;

  // Widest flux vector any scheduler built on this package may use.
  localparam int unsigned MAX_FLUX  = 16;
  localparam int unsigned MAX_TAG_W = 4;

  // Binary tag width for n fluxes; never narrower than one bit.
  function automatic int unsigned tag_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEFAULT_FLUX = 2;
  localparam int unsigned TAG_W        = tag_w(DEFAULT_FLUX);

  typedef logic [MAX_FLUX-1:0] flux_vec_t;

  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
  } pick_t;

  // First set bit of elig scanning ptr, ptr+1, ..., n-1, 0, ..., ptr-1.
  // ptr must be below n; wrap is done by subtraction so n need not be a power of two.
  function automatic pick_t rr_pick(input flux_vec_t elig, input int unsigned ptr,
                                    input int unsigned n);
    pick_t       r;
    int unsigned idx;
    r = '0;
    for (int unsigned i = 0; i < MAX_FLUX; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if ((i < n) && !r.valid && elig[idx[MAX_TAG_W-1:0]]) begin
        r.valid = 1'b1;
        r.tag   = idx[MAX_TAG_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/flux_rr_sched_pick.sv
// Pure combinational rotate-priority encoder, reusable by any multi-flux actor.
module rr_pick_comb
  import flux_sched_pkg::*;
#(
  parameter int unsigned FLUX      = 2,
  parameter int unsigned TAG_WIDTH = tag_w(FLUX)
) (
  input  logic [FLUX-1:0]      elig,
  input  logic [TAG_WIDTH-1:0] ptr,
  output logic                 valid,
  output logic [TAG_WIDTH-1:0] tag
);

  flux_vec_t elig_ext;
  pick_t     pick;
  logic      unused_tag_hi;

  // Widen to the package vector, pick, then narrow the tag back to TAG_WIDTH.
  always_comb begin
    elig_ext                = '0;
    elig_ext[FLUX-1:0]      = elig;
    pick                    = rr_pick(elig_ext, 32'(ptr), FLUX);
    valid                   = pick.valid;
    tag                     = pick.tag[TAG_WIDTH-1:0];
    unused_tag_hi           = ^pick.tag;
  end

endmodule

// File: rtl/flux_rr_sched.sv
// Masked round-robin flux scheduler with burst quota and no-preemption lock.
module flux_rr_sched
  import flux_sched_pkg::*;
#(
  parameter int unsigned FLUX      = 2,
  parameter int unsigned BURST     = 4,
  parameter int unsigned TAG_WIDTH = tag_w(FLUX)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLUX-1:0]      req,
  input  logic                 fire,
  input  logic                 cfg_mask_we,
  input  logic [FLUX-1:0]      cfg_mask,
  output logic                 gnt_valid,
  output logic [TAG_WIDTH-1:0] gnt_tag,
  output logic [FLUX-1:0]      gnt_onehot,
  output logic [FLUX-1:0]      mask_q,
  output logic [15:0]          fire_cnt
);

  localparam logic [0:0]           FREE     = 1'b0;
  localparam logic [0:0]           HELD     = 1'b1;
  localparam logic [3:0]           BURST_N  = 4'(BURST);
  localparam logic [TAG_WIDTH-1:0] TAG_LAST = TAG_WIDTH'(FLUX - 1);

  logic [0:0]           lock_state;
  logic [TAG_WIDTH-1:0] lock_tag;
  logic [TAG_WIDTH-1:0] ptr;
  logic [TAG_WIDTH-1:0] last_tag;
  logic [3:0]           burst_cnt;
  logic [3:0]           run_len;
  logic [FLUX-1:0]      elig;
  logic                 lock_hit;
  logic                 fired;
  logic                 pick_valid;
  logic [TAG_WIDTH-1:0] pick_tag;

  rr_pick_comb #(
    .FLUX      (FLUX),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_pick (
    .elig  (elig),
    .ptr   (ptr),
    .valid (pick_valid),
    .tag   (pick_tag)
  );

  // Grant: held flux first, else rotate scan from ptr; silent during reset.
  always_comb begin
    elig       = req & mask_q;
    lock_hit   = (lock_state == HELD) && elig[lock_tag];
    gnt_valid  = 1'b0;
    gnt_tag    = '0;
    gnt_onehot = '0;
    if (!rst) begin
      if (lock_hit) begin
        gnt_valid = 1'b1;
        gnt_tag   = lock_tag;
      end else if (pick_valid) begin
        gnt_valid = 1'b1;
        gnt_tag   = pick_tag;
      end
    end
    if (gnt_valid) gnt_onehot[gnt_tag] = 1'b1;
    fired   = gnt_valid & fire;
    // burst_cnt counts fires already in the current run, so the run closes after
    // exactly BURST consecutive fires, the first fire on a new tag included.
    run_len = (gnt_tag == last_tag) ? (burst_cnt + 4'd1) : 4'd1;
  end

  // Lock FSM, burst/rotation pointer, mask register and fire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_state <= FREE;
      lock_tag   <= '0;
      ptr        <= '0;
      last_tag   <= '0;
      burst_cnt  <= '0;
      mask_q     <= '1;
      fire_cnt   <= '0;
    end else begin
      if (cfg_mask_we) mask_q <= cfg_mask;

      if (fired) begin
        fire_cnt <= fire_cnt + 16'd1;
        last_tag <= gnt_tag;
        if (run_len >= BURST_N) begin
          burst_cnt <= '0;
          ptr       <= (gnt_tag == TAG_LAST) ? '0 : gnt_tag + TAG_WIDTH'(1);
        end else begin
          burst_cnt <= run_len;
          ptr       <= gnt_tag;
        end
      end else if (!elig[ptr]) begin
        burst_cnt <= '0;
      end

      case (lock_state)
        FREE: begin
          if (gnt_valid && !fire) begin
            lock_state <= HELD;
            lock_tag   <= gnt_tag;
          end
        end
        HELD: begin
          if (fired || !elig[lock_tag]) lock_state <= FREE;
        end
        default: lock_state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_flux_rr_sched.sv
// Directed bench for flux_rr_sched: FLUX=2/BURST=4 and FLUX=3/BURST=1 instances.
module tb_flux_rr_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req, cfg_mask, gnt_onehot, mask_q;
  logic        fire, cfg_mask_we, gnt_valid;
  logic [0:0]  gnt_tag;
  logic [15:0] fire_cnt;

  logic [2:0]  req3, cfg_mask3, gnt_onehot3, mask_q3;
  logic        fire3, cfg_mask_we3, gnt_valid3;
  logic [1:0]  gnt_tag3;
  logic [15:0] fire_cnt3;

  int checks   = 0;
  int failures = 0;

  flux_rr_sched #(.FLUX(2), .BURST(4)) u_dut (
    .clk(clk), .rst(rst), .req(req), .fire(fire),
    .cfg_mask_we(cfg_mask_we), .cfg_mask(cfg_mask),
    .gnt_valid(gnt_valid), .gnt_tag(gnt_tag), .gnt_onehot(gnt_onehot),
    .mask_q(mask_q), .fire_cnt(fire_cnt)
  );

  flux_rr_sched #(.FLUX(3), .BURST(1)) u_dut3 (
    .clk(clk), .rst(rst), .req(req3), .fire(fire3),
    .cfg_mask_we(cfg_mask_we3), .cfg_mask(cfg_mask3),
    .gnt_valid(gnt_valid3), .gnt_tag(gnt_tag3), .gnt_onehot(gnt_onehot3),
    .mask_q(mask_q3), .fire_cnt(fire_cnt3)
  );

  task automatic do_reset();
    rst = 1'b1; req = '0; fire = 1'b0; req3 = '0; fire3 = 1'b0; cfg_mask_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b11; fire = 1'b1; req3 = 3'b111; fire3 = 1'b1;
    cfg_mask_we = 1'b0; cfg_mask = 2'b00; cfg_mask_we3 = 1'b0; cfg_mask3 = 3'b000;
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b0 || gnt_tag !== 1'b0 || gnt_onehot !== 2'b00) begin
      failures++;
      $display("FAIL reset_grant2: valid=%b tag=%0d onehot=%b required 0/0/00", gnt_valid, gnt_tag, gnt_onehot);
    end
    checks++;
    if (gnt_valid3 !== 1'b0 || gnt_tag3 !== 2'd0 || gnt_onehot3 !== 3'b000) begin
      failures++;
      $display("FAIL reset_grant3: valid=%b tag=%0d onehot=%b required 0/0/000", gnt_valid3, gnt_tag3, gnt_onehot3);
    end
    @(posedge clk); #1;
    rst = 1'b0; req = '0; fire = 1'b0; req3 = '0; fire3 = 1'b0;
    @(negedge clk);
    checks++;
    if (mask_q !== 2'b11 || fire_cnt !== 16'd0 || gnt_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state2: mask=%b cnt=%0d valid=%b required 11/0/0", mask_q, fire_cnt, gnt_valid);
    end
    checks++;
    if (mask_q3 !== 3'b111 || fire_cnt3 !== 16'd0) begin
      failures++;
      $display("FAIL reset_state3: mask=%b cnt=%0d required 111/0", mask_q3, fire_cnt3);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic [0:0] exp_tag;
    do_reset();
    req = 2'b11; fire = 1'b1;
    for (int k = 0; k < 9; k++) begin
      exp_tag = 1'((k / 4) % 2);
      @(negedge clk);
      checks++;
      if (gnt_valid !== 1'b1 || gnt_tag !== exp_tag || gnt_onehot !== (2'b01 << exp_tag)) begin
        failures++;
        $display("FAIL rr_seq[%0d]: valid=%b tag=%0d onehot=%b required 1/%0d", k, gnt_valid, gnt_tag, gnt_onehot, exp_tag);
      end
      if (k == 8) begin
        checks++;
        if (fire_cnt !== 16'd8) begin
          failures++;
          $display("FAIL rr_count: fire_cnt=%0d required 8", fire_cnt);
        end
      end
      @(posedge clk); #1;
    end
    fire = 1'b0;
  endtask

  task automatic test_hold();
    logic [0:0] exp_tag;
    do_reset();
    req = 2'b11; fire = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    req = 2'b01; fire = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (gnt_valid !== 1'b1 || gnt_tag !== 1'b0) begin
        failures++;
        $display("FAIL hold_idle[%0d]: valid=%b tag=%0d required 1/0", k, gnt_valid, gnt_tag);
      end
      @(posedge clk); #1;
    end
    req = 2'b11;
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b1 || gnt_tag !== 1'b0) begin
      failures++;
      $display("FAIL hold_no_preempt: valid=%b tag=%0d required 1/0", gnt_valid, gnt_tag);
    end
    @(posedge clk); #1;
    fire = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_tag = (k < 4) ? 1'b0 : 1'b1;
      @(negedge clk);
      checks++;
      if (gnt_valid !== 1'b1 || gnt_tag !== exp_tag) begin
        failures++;
        $display("FAIL hold_burst[%0d]: valid=%b tag=%0d required 1/%0d", k, gnt_valid, gnt_tag, exp_tag);
      end
      @(posedge clk); #1;
    end
    fire = 1'b0;
    @(negedge clk);
    checks++;
    if (fire_cnt !== 16'd9) begin
      failures++;
      $display("FAIL hold_count: fire_cnt=%0d required 9", fire_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flux3();
    logic [1:0] exp_tag;
    do_reset();
    req3 = 3'b101; fire3 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_tag = (k % 2 == 0) ? 2'd0 : 2'd2;
      @(negedge clk);
      checks++;
      if (gnt_valid3 !== 1'b1 || gnt_tag3 !== exp_tag || gnt_onehot3 !== (3'b001 << exp_tag)) begin
        failures++;
        $display("FAIL flux3_alt[%0d]: valid=%b tag=%0d onehot=%b required 1/%0d", k, gnt_valid3, gnt_tag3, gnt_onehot3, exp_tag);
      end
      @(posedge clk); #1;
    end
    req3 = '0; fire3 = 1'b0;
  endtask

  task automatic test_mask();
    do_reset();
    req = 2'b11; fire = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b1 || gnt_tag !== 1'b0) begin
      failures++;
      $display("FAIL mask_hold0: valid=%b tag=%0d required 1/0", gnt_valid, gnt_tag);
    end
    @(posedge clk); #1;
    cfg_mask_we = 1'b1; cfg_mask = 2'b10;
    @(negedge clk);
    checks++;
    if (gnt_tag !== 1'b0 || mask_q !== 2'b11) begin
      failures++;
      $display("FAIL mask_pending: tag=%0d mask=%b required 0/11", gnt_tag, mask_q);
    end
    @(posedge clk); #1;
    cfg_mask_we = 1'b0;
    @(negedge clk);
    checks++;
    if (mask_q !== 2'b10 || gnt_valid !== 1'b1 || gnt_tag !== 1'b1 || gnt_onehot !== 2'b10) begin
      failures++;
      $display("FAIL mask_switch: mask=%b valid=%b tag=%0d onehot=%b required 10/1/1/10", mask_q, gnt_valid, gnt_tag, gnt_onehot);
    end
    @(posedge clk); #1;
    fire = 1'b1; cfg_mask_we = 1'b1; cfg_mask = 2'b00;
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b1 || gnt_tag !== 1'b1) begin
      failures++;
      $display("FAIL mask_fire_write: valid=%b tag=%0d required 1/1", gnt_valid, gnt_tag);
    end
    @(posedge clk); #1;
    cfg_mask_we = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (gnt_valid !== 1'b0 || gnt_tag !== 1'b0 || gnt_onehot !== 2'b00 || fire_cnt !== 16'd1) begin
        failures++;
        $display("FAIL mask_zero[%0d]: valid=%b tag=%0d onehot=%b cnt=%0d required 0/0/00/1", k, gnt_valid, gnt_tag, gnt_onehot, fire_cnt);
      end
      @(posedge clk); #1;
    end
    fire = 1'b0; cfg_mask_we = 1'b1; cfg_mask = 2'b11;
    @(posedge clk); #1;
    cfg_mask_we = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b1 || gnt_tag !== 1'b1) begin
      failures++;
      $display("FAIL mask_restore: valid=%b tag=%0d required 1/1", gnt_valid, gnt_tag);
    end
    @(posedge clk); #1;
    req = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 2'b11; fire = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (gnt_tag !== 1'b1 || fire_cnt !== 16'd6) begin
      failures++;
      $display("FAIL midrst_before: tag=%0d cnt=%0d required 1/6", gnt_tag, fire_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b0 || gnt_tag !== 1'b0 || gnt_onehot !== 2'b00) begin
      failures++;
      $display("FAIL midrst_during: valid=%b tag=%0d onehot=%b required 0/0/00", gnt_valid, gnt_tag, gnt_onehot);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b1 || gnt_tag !== 1'b0 || fire_cnt !== 16'd0) begin
      failures++;
      $display("FAIL midrst_after: valid=%b tag=%0d cnt=%0d required 1/0/0", gnt_valid, gnt_tag, fire_cnt);
    end
    fire = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    int bad = 0;
    do_reset();
    req = 2'b11; fire = 1'b1;
    for (int k = 0; k < 65536; k++) begin
      @(negedge clk);
      if (gnt_valid !== 1'b1 || gnt_tag !== 1'((k / 4) % 2) || fire_cnt !== 16'(k)) bad++;
      if (k == 65535) begin
        checks++;
        if (fire_cnt !== 16'hFFFF) begin
          failures++;
          $display("FAIL wrap_top: fire_cnt=%0d required 65535", fire_cnt);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL wrap_stream: bad_cycles=%0d required 0", bad);
    end
    @(negedge clk);
    checks++;
    if (fire_cnt !== 16'd0 || gnt_valid !== 1'b1 || gnt_tag !== 1'b0) begin
      failures++;
      $display("FAIL wrap_zero: cnt=%0d valid=%b tag=%0d required 0/1/0", fire_cnt, gnt_valid, gnt_tag);
    end
    fire = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_hold();
    test_flux3();
    test_mask();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
